// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_channel_decoder
// Description : TMDS receive lane. Finds the 10-bit symbol boundary in the
//               unaligned deserializer words by bit-slipping until a run of
//               control tokens is seen, then decodes each aligned symbol to
//               video data or control data plus VDE.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder #(
  parameter int LOCK_CNT       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [9:0] in_word,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] bit_offset
);

  // Counters only need to reach their terminal values (parameter - 1).
  localparam int RUN_W   = (LOCK_CNT > 1)       ? $clog2(LOCK_CNT)       : 1;
  localparam int DWELL_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int LOSS_W  = (LOSS_TIMEOUT > 1)   ? $clog2(LOSS_TIMEOUT)   : 1;

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [9:0]         prev;
  logic [RUN_W-1:0]   run_cnt, run_next;
  logic [DWELL_W-1:0] dwell, dwell_next;
  logic [LOSS_W-1:0]  loss, loss_next;
  logic [3:0]         offset_next;

  logic [19:0]        stream;
  logic [9:0]         window [10];
  logic [9:0]         symbol;
  logic               is_token;
  logic [1:0]         token_cd;
  logic [7:0]         q;
  logic [7:0]         data;

  // Older word in the low half so that offset 0 selects prev unchanged.
  assign stream = {in_word, prev};

  for (genvar g = 0; g < 10; g++) begin : g_win
    assign window[g] = stream[g+9:g];
  end

  // Pick the candidate symbol at the current slip offset.
  always_comb begin
    symbol = window[0];
    for (int k = 1; k < 10; k++) begin
      if (bit_offset == 4'(k)) symbol = window[k];
    end
  end

  // Recognise the four control tokens.
  always_comb begin
    is_token = 1'b1;
    token_cd = 2'b00;
    case (symbol)
      10'b1101010100: token_cd = 2'b00;
      10'b0010101011: token_cd = 2'b01;
      10'b0101010100: token_cd = 2'b10;
      10'b1010101011: token_cd = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chaining.
  always_comb begin
    q       = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    data    = 8'h00;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM: next state, counters and slip offset.
  always_comb begin
    state_next  = state;
    run_next    = run_cnt;
    dwell_next  = dwell;
    loss_next   = loss;
    offset_next = bit_offset;
    case (state)
      SEARCH: begin
        if (is_token && (run_cnt == RUN_LAST)) begin
          // Lock wins over a slip falling due in the same cycle.
          state_next = LOCKED;
          run_next   = '0;
          dwell_next = '0;
          loss_next  = '0;
        end else if (dwell == DWELL_LAST) begin
          offset_next = (bit_offset >= 4'd9) ? 4'd0 : bit_offset + 4'd1;
          run_next    = '0;
          dwell_next  = '0;
        end else begin
          run_next   = is_token ? run_cnt + 1'b1 : '0;
          dwell_next = dwell + 1'b1;
        end
      end
      LOCKED: begin
        if (is_token) begin
          loss_next = '0;
        end else if (loss == LOSS_LAST) begin
          // Offset is kept so the search resumes where the link last was.
          state_next = SEARCH;
          loss_next  = '0;
          run_next   = '0;
          dwell_next = '0;
        end else begin
          loss_next = loss + 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // State, counters, word history and registered outputs.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state      <= SEARCH;
      prev       <= 10'd0;
      run_cnt    <= '0;
      dwell      <= '0;
      loss       <= '0;
      bit_offset <= 4'd0;
      locked     <= 1'b0;
      vd         <= 8'h00;
      cd         <= 2'b00;
      vde        <= 1'b0;
    end else begin
      state      <= state_next;
      prev       <= in_word;
      run_cnt    <= run_next;
      dwell      <= dwell_next;
      loss       <= loss_next;
      bit_offset <= offset_next;
      locked     <= (state_next == LOCKED);
      // Outputs follow the lock flag they are registered with, so a
      // deasserted locked is always paired with idle outputs.
      if (state_next == LOCKED) begin
        if (is_token) begin
          vde <= 1'b0;
          cd  <= token_cd;
        end else begin
          vde <= 1'b1;
          vd  <= data;
        end
      end else begin
        vd  <= 8'h00;
        cd  <= 2'b00;
        vde <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_channel_decoder
// Description : Directed bench for the TMDS lane decoder with a bit-stream
//               generator, a reference TMDS encoder and a per-cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

  localparam int LOCK_CNT       = 8;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int LOSS_TIMEOUT   = 2048;

  localparam logic [9:0] TOK_A = 10'b1101010100;  // cd 00
  localparam logic [9:0] TOK_B = 10'b0010101011;  // cd 01
  localparam logic [9:0] TOK_C = 10'b0101010100;  // cd 10
  localparam logic [9:0] TOK_D = 10'b1010101011;  // cd 11

  logic       pixclk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] in_word = 10'd0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       locked;
  logic [3:0] bit_offset;

  tmds_channel_decoder #(
    .LOCK_CNT      (LOCK_CNT),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) dut (
    .pixclk    (pixclk),
    .reset     (reset),
    .in_word   (in_word),
    .vd        (vd),
    .cd        (cd),
    .vde       (vde),
    .locked    (locked),
    .bit_offset(bit_offset)
  );

  always #5 pixclk = ~pixclk;

  int n_vec = 0;
  int n_err = 0;

  // Model state (values the DUT registers must hold after each edge)
  logic [9:0] m_prev = 10'd0;
  int         m_off  = 0;
  bit         m_lock = 1'b0;
  int         m_run = 0, m_dwell = 0, m_loss = 0;
  logic [7:0] m_vd  = 8'h00;
  logic [1:0] m_cd  = 2'b00;
  logic       m_vde = 1'b0;

  bit         chk_en   = 1'b0;
  bit         frame_en = 1'b0;
  int         run_len    = 0;
  int         frame_runs = 0;
  logic [7:0] pixq [$];

  // Serial stream generator: symbols delayed by dly bits across words
  int         dly = 0;
  logic [9:0] last_sym = 10'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int token_index(input logic [9:0] s);
    logic [9:0] tab [4];
    int idx;
    tab = '{TOK_A, TOK_B, TOK_C, TOK_D};
    idx = -1;
    for (int i = 0; i < 4; i++) if (s == tab[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [9:0] token_of(input logic [1:0] c);
    logic [9:0] tab [4];
    tab = '{TOK_A, TOK_B, TOK_C, TOK_D};
    return tab[c];
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] qq, dd;
    qq = s[9] ? ~s[7:0] : s[7:0];
    dd[0] = qq[0];
    for (int i = 1; i < 8; i++) dd[i] = s[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
    return dd;
  endfunction

  // Reference transition-minimising encoder (transmit side)
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    int n1;
    logic use_xnor, inv;
    logic [7:0] qm;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || ((n1 == 4) && (d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    inv = ($countones(qm) > 4);
    return {inv, ~use_xnor, inv ? ~qm : qm};
  endfunction

  task automatic model_edge(input logic [9:0] w, input logic r);
    logic [19:0] st;
    logic [9:0]  sym;
    int          ti;
    if (r) begin
      m_prev = 10'd0; m_off = 0; m_lock = 1'b0;
      m_run = 0; m_dwell = 0; m_loss = 0;
      m_vd = 8'h00; m_cd = 2'b00; m_vde = 1'b0;
    end else begin
      st  = {w, m_prev};
      sym = 10'(st >> m_off);
      ti  = token_index(sym);
      if (!m_lock) begin
        m_run = (ti >= 0) ? m_run + 1 : 0;
        if (m_run == LOCK_CNT) begin
          m_lock = 1'b1; m_run = 0; m_dwell = 0; m_loss = 0;
        end else if (m_dwell == SEARCH_TIMEOUT - 1) begin
          m_off = (m_off + 1) % 10; m_run = 0; m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end else begin
        if (ti >= 0) m_loss = 0;
        else if (m_loss == LOSS_TIMEOUT - 1) begin
          m_lock = 1'b0; m_loss = 0; m_run = 0; m_dwell = 0;
        end else m_loss++;
      end
      if (m_lock) begin
        if (ti >= 0) begin m_vde = 1'b0; m_cd = 2'(ti); end
        else begin m_vde = 1'b1; m_vd = decode(sym); end
      end else begin
        m_vd = 8'h00; m_cd = 2'b00; m_vde = 1'b0;
      end
      m_prev = w;
    end
  endtask

  task automatic step(input logic [9:0] w);
    @(negedge pixclk);
    in_word = w;
    @(posedge pixclk);
    #1;
    model_edge(w, reset);
  endtask

  task automatic send(input logic [9:0] s);
    logic [19:0] t;
    t = {s, last_sym};
    last_sym = s;
    step(10'(t >> (10 - dly)));
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step(10'd0);
    reset = 1'b0;
    last_sym = 10'd0;
  endtask

  // Per-cycle comparison against the model, plus frame-level bookkeeping
  always @(negedge pixclk) begin : cmp
    logic [7:0] exp_px;
    if (chk_en) begin
      check("vd", vd, m_vd);
      check("cd", cd, m_cd);
      check("vde", vde, m_vde);
      check("locked", locked, m_lock);
      check("bit_offset", bit_offset, m_off);
      if (frame_en) begin
        if (vde === 1'b1) begin
          run_len++;
          if (pixq.size() > 0) begin
            exp_px = pixq.pop_front();
            check("pixel", vd, exp_px);
          end else begin
            n_vec++; n_err++;
            $display("FAIL pixel: vde high with no pixel outstanding at %0t", $time);
          end
        end else if (run_len != 0) begin
          check("line_vde_len", run_len, 640);
          frame_runs++;
          run_len = 0;
        end
      end
    end
  end

  initial begin
    // Reset state
    reset_dut();
    chk_en = 1'b1;
    check("rst_vd", vd, 0);
    check("rst_cd", cd, 0);
    check("rst_vde", vde, 0);
    check("rst_locked", locked, 0);
    check("rst_offset", bit_offset, 0);

    // Aligned token stream: 8th sampled token locks at offset 0
    dly = 0;
    for (int i = 1; i <= 9; i++) begin
      send(TOK_A);
      if (i == 8) check("t1_not_yet", locked, 0);
    end
    check("t1_locked", locked, 1);
    check("t1_offset", bit_offset, 0);
    check("t1_cd", cd, 0);
    check("t1_vde", vde, 0);

    // 3-bit delayed stream: slips at 1024-cycle intervals, locks at 3
    reset_dut();
    dly = 3;
    for (int i = 1; i <= 3080; i++) begin
      send(TOK_D);
      if (i == 1023) check("t2_off_0", bit_offset, 0);
      if (i == 1024) check("t2_off_1", bit_offset, 1);
      if (i == 2048) check("t2_off_2", bit_offset, 2);
      if (i == 3072) check("t2_off_3", bit_offset, 3);
      if (i == 3079) check("t2_not_yet", locked, 0);
    end
    check("t2_locked", locked, 1);
    check("t2_offset", bit_offset, 3);
    check("t2_cd", cd, 3);

    // Data symbols then a token, each visible one step after it is sent
    send(TOK_D);
    send(TOK_D);
    send(10'h100);
    send(10'h200);
    check("t3_vde_a", vde, 1);
    check("t3_vd_a", vd, 8'h00);
    send(TOK_C);
    check("t3_vde_b", vde, 1);
    check("t3_vd_b", vd, 8'hFF);
    send(TOK_C);
    check("t3_vde_c", vde, 0);
    check("t3_cd_c", cd, 2);
    check("t3_vd_hold", vd, 8'hFF);

    // Shortened frame: 800-cycle lines, 640 active, hSync/vSync tokens
    frame_en = 1'b1;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 800; x++) begin
        logic vs, hs;
        logic [7:0] px;
        vs = (y == 3) || (y == 4);
        hs = (x >= 656) && (x < 752);
        if (!vs && (x < 640)) begin
          px = 8'(x + 37 * y);
          pixq.push_back(px);
          send(tmds_enc(px));
        end else begin
          send(token_of({vs, hs}));
        end
      end
    end
    send(TOK_A);
    send(TOK_A);
    send(TOK_A);
    frame_en = 1'b0;
    check("t4_lines", frame_runs, 4);
    check("t4_pix_left", pixq.size(), 0);
    check("t4_locked", locked, 1);

    // Loss of tokens: drops on the LOSS_TIMEOUT-th data symbol, then relock
    for (int i = 1; i <= LOSS_TIMEOUT; i++) send(10'h100);
    check("t5_still", locked, 1);
    send(10'h100);
    check("t5_lost", locked, 0);
    check("t5_offset", bit_offset, 3);
    check("t5_vde", vde, 0);
    for (int i = 1; i <= 8; i++) send(TOK_B);
    check("t5_not_yet", locked, 0);
    send(TOK_B);
    check("t5_relock", locked, 1);
    check("t5_cd", cd, 1);

    // Lock at offset 5, then a single-cycle reset
    reset_dut();
    dly = 5;
    for (int i = 1; i <= 5128; i++) begin
      send(TOK_A);
      if (i == 5127) check("t6_not_yet", locked, 0);
    end
    check("t6_locked", locked, 1);
    check("t6_offset", bit_offset, 5);
    send(tmds_enc(8'hA5));
    send(TOK_B);
    send(TOK_B);
    check("t6_vd", vd, 8'hA5);
    check("t6_cd", cd, 1);
    reset = 1'b1;
    step(TOK_B);
    reset = 1'b0;
    last_sym = 10'd0;
    check("t6_rst_locked", locked, 0);
    check("t6_rst_offset", bit_offset, 0);
    check("t6_rst_vde", vde, 0);
    check("t6_rst_vd", vd, 0);
    check("t6_rst_cd", cd, 0);
    send(TOK_A);
    send(TOK_A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
